sequence_generator: RTL and testbench

//   Serial bit-pattern transmitter; the source-side counterpart of the serial pattern detector.

---
 rtl/sequence_generator_pkg.sv | 18 +
 rtl/sequence_generator_piso_shift.sv | 28 ++
 rtl/sequence_generator.sv | 145 ++++++++++++++
 tb/tb_sequence_generator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sequence_generator_pkg.sv
// Shared types and width helpers for the serial sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int GAP_CNT_W = 4;

  // Bit-counter width for a W-bit word; W >= 2, so $clog2 never yields 0.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sequence_generator_piso_shift.sv
// Parallel-in serial-out register: parallel load, MSB-first shift, shift enable.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  output logic         dout
);

  logic [W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load)          sh_d = load_data;
    else if (shift_en) sh_d = {sh_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign dout = sh_q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter, MSB first, registered outputs.
// Optional feature: define PARITY_EN to append an even-parity bit after each word.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int W   = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         out,
  output logic         out_valid,
  output logic         done,
  output logic         busy
);

  localparam int CNT_W = cnt_w(W);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic                 load_ready_q, load_ready_d;
  logic                 accept, shift_en, sh_bit;

  assign accept = load_valid && load_ready_q && (state_q == S_IDLE);

  // The MSB goes straight to out_q on acceptance, so the shifter holds the remaining bits.
  piso_shift #(.W(W)) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data ({load_data[W-2:0], 1'b0}),
    .shift_en  (shift_en),
    .dout      (sh_bit)
  );

`ifdef PARITY_EN
  logic par_q, par_d;
  always_comb par_d = accept ? ^load_data : par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    out_d        = 1'b0;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    load_ready_d = 1'b0;
    shift_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_SHIFT;
          bit_cnt_d   = CNT_W'(W - 1);
          out_d       = load_data[W-1];
          out_valid_d = 1'b1;
        end else begin
          load_ready_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_en    = 1'b1;
          bit_cnt_d   = bit_cnt_q - 1'b1;
          out_d       = sh_bit;
          out_valid_d = 1'b1;
`ifndef PARITY_EN
          done_d      = (bit_cnt_q == CNT_W'(1));
`endif
        end else begin
`ifdef PARITY_EN
          state_d     = S_PAR;
          out_d       = par_q;
          out_valid_d = 1'b1;
          done_d      = 1'b1;
`else
          if (GAP == 0) begin
            state_d      = S_IDLE;
            load_ready_d = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_CNT_W'(GAP - 1);
          end
`endif
        end
      end
      S_PAR: begin
        if (GAP == 0) begin
          state_d      = S_IDLE;
          load_ready_d = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_CNT_W'(GAP - 1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d      = S_IDLE;
          load_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: per-cycle expected outputs come from a frame queue model.
module tb_sequence_generator;

  localparam int W   = 8;
  localparam int GAP = 1;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, out, out_valid, done, busy;

  sequence_generator #(.W(W), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc_n  = 0;
  int acc_cyc[$];
  // Entry = {out, out_valid, done, busy, load_ready}
  logic [4:0] exp_q[$];
  bit post_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc_n);
  endtask

  function automatic logic [4:0] model_cur();
    if (exp_q.size() > 0) return exp_q[0];
    return {4'b0000, ~post_rst};
  endfunction

  // A frame: W data bits MSB first, optional parity bit, then GAP idle cycles, all busy.
  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--)
      exp_q.push_back({d[i], 1'b1, (i == 0 && PAR == 0), 1'b1, 1'b0});
    if (PAR != 0) exp_q.push_back({^d, 1'b1, 1'b1, 1'b1, 1'b0});
    for (int g = 0; g < GAP; g++) exp_q.push_back(5'b00010);
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d);
    logic [4:0] e;
    bit acc;
    load_valid = v;
    load_data  = d;
    @(negedge clk);
    e = model_cur();
    chk("outputs", {27'd0, out, out_valid, done, busy, load_ready}, {27'd0, e});
    acc = v && e[0];
    if (acc) acc_cyc.push_back(cyc_n);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    post_rst = 1'b0;
    if (acc) push_frame(d);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  initial begin
    int n0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {27'd0, out, out_valid, done, busy, load_ready}, 32'd0);
    rst_n = 1'b1;
    post_rst = 1'b1;

    // Reset release then the 1000_1011 directed frame
    idle(2);
    cyc(1'b1, 8'b1000_1011);
    idle(W + GAP + PAR + 2);

    // Back-to-back with load_valid held high
    n0 = acc_cyc.size();
    cyc(1'b1, 8'hF0);
    for (int i = 0; i < 30 && acc_cyc.size() < n0 + 2; i++) cyc(1'b1, 8'h0F);
    chk("b2b_accepts", acc_cyc.size(), n0 + 2);
    if (acc_cyc.size() >= n0 + 2)
      chk("b2b_spacing", acc_cyc[n0+1] - acc_cyc[n0], W + GAP + 1 + PAR);
    idle(W + GAP + PAR + 2);

    // load_valid pulsed mid-frame must be ignored
    cyc(1'b1, 8'h00);
    idle(3);
    cyc(1'b1, 8'hFF);
    idle(W + GAP + PAR + 2);

    // Parity-sensitive words
    cyc(1'b1, 8'hA5);
    idle(W + GAP + PAR + 1);
    cyc(1'b1, 8'h07);
    idle(W + GAP + PAR + 1);

    // Reset mid-frame aborts immediately
    cyc(1'b1, 8'hAA);
    idle(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {27'd0, out, out_valid, done, busy, load_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_held_outs", {27'd0, out, out_valid, done, busy, load_ready}, 32'd0);
    rst_n = 1'b1;
    post_rst = 1'b1;
    idle(1);
    cyc(1'b1, 8'h81);
    idle(W + GAP + PAR + 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 2) == 0), W'($urandom));
    idle(W + GAP + PAR + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
